// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: operation codes, FSM states and the
// helper that decides whether an op code names a real HI/LO instruction.
package hilo_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Unknown encodings behave exactly like OP_NONE.
    function automatic logic op_active(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_active = 1'b1;
            default:                                             op_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_unit_mul.sv
// Registered 32x32 -> 64 multiplier, signed or unsigned, one cycle of latency.
// The product register only loads when en is high so it holds for the commit cycle.
module hilo_mul
    import hilo_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [PROD_W-1:0]   product
);

    logic [DATA_W:0]   a_ext_s;
    logic [DATA_W:0]   b_ext_s;
    logic [PROD_W-1:0] a_wide_s;
    logic [PROD_W-1:0] b_wide_s;
    logic [PROD_W-1:0] product_d;
    logic [PROD_W-1:0] product_q;

    // 33-bit extension makes one signed multiply cover both MULT and MULTU;
    // the low 64 bits of a 64x64 multiply are the exact 33x33 product.
    always_comb begin
        a_ext_s  = {is_signed & a[DATA_W-1], a};
        b_ext_s  = {is_signed & b[DATA_W-1], b};
        a_wide_s = {{(PROD_W-DATA_W-1){a_ext_s[DATA_W]}}, a_ext_s};
        b_wide_s = {{(PROD_W-DATA_W-1){b_ext_s[DATA_W]}}, b_ext_s};
        if (en) begin
            product_d = a_wide_s * b_wide_s;
        end else begin
            product_d = product_q;
        end
    end

    // Product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= 64'd0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO writes, two-cycle multiplies through hilo_mul and
// divides sequenced through an external divider via its start/busy/clr handshake.
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    input  logic                flush,
    output logic                stall,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                div_start,
    output logic                div_clr,
    output logic                div_sign,
    output logic [DATA_W-1:0]   div_a,
    output logic [DATA_W-1:0]   div_b,
    input  logic [PROD_W-1:0]   div_result,
    input  logic                div_busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   div_a_q, div_a_d;
    logic [DATA_W-1:0]   div_b_q, div_b_d;
    logic                div_sign_q, div_sign_d;
    logic                div_start_q, div_start_d;
    logic                busy_seen_q, busy_seen_d;
    logic                stall_s;
    logic                mul_en_s;
    logic [PROD_W-1:0]   product_s;

    hilo_mul u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (mul_en_s),
        .is_signed (op == OP_MULT),
        .a         (rs_val),
        .b         (rt_val),
        .product   (product_s)
    );

    // Next-state, HI/LO write and stall decode; flush overrides every state.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        div_sign_d  = div_sign_q;
        div_start_d = div_start_q;
        busy_seen_d = busy_seen_q;
        stall_s     = 1'b0;
        mul_en_s    = 1'b0;

        if (flush) begin
            div_start_d = 1'b0;
            busy_seen_d = 1'b0;
            if (state_q == ST_DIV) begin
                state_d = ST_RELEASE;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        case (op)
                            OP_MTHI: hi_d = rs_val;
                            OP_MTLO: lo_d = rs_val;
                            OP_MULT, OP_MULTU: begin
                                mul_en_s = 1'b1;
                                stall_s  = 1'b1;
                                state_d  = ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                div_a_d     = rs_val;
                                div_b_d     = rt_val;
                                div_sign_d  = (op == OP_DIV);
                                div_start_d = 1'b1;
                                busy_seen_d = 1'b0;
                                stall_s     = 1'b1;
                                state_d     = ST_DIV;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    hi_d    = product_s[PROD_W-1:DATA_W];
                    lo_d    = product_s[DATA_W-1:0];
                    state_d = ST_IDLE;
                end
                ST_DIV: begin
                    // busy is low before the divider has sampled start, so only a
                    // low busy after a high one marks completion.
                    if (div_busy) begin
                        busy_seen_d = 1'b1;
                        stall_s     = 1'b1;
                    end else if (busy_seen_q) begin
                        hi_d        = div_result[PROD_W-1:DATA_W];
                        lo_d        = div_result[DATA_W-1:0];
                        div_start_d = 1'b0;
                        busy_seen_d = 1'b0;
                        state_d     = ST_RELEASE;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    stall_s = valid & op_active(op);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, architectural HI/LO and divider handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            div_a_q     <= 32'd0;
            div_b_q     <= 32'd0;
            div_sign_q  <= 1'b0;
            div_start_q <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_sign_q  <= div_sign_d;
            div_start_q <= div_start_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    assign stall     = rst_n & stall_s;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_start = div_start_q;
    assign div_clr   = flush;
    assign div_sign  = div_sign_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural 32-cycle divider and an
// architectural HI/LO model checked every cycle.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        flush;
    logic        stall;
    logic [31:0] hi, lo;
    logic        div_start, div_clr, div_sign;
    logic [31:0] div_a, div_b;
    logic [63:0] div_result;
    logic        div_busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    bit cmp_en = 1'b0;

    int dv_state;
    int dv_cnt;

    hilo_unit dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
        .hi(hi), .lo(lo), .div_start(div_start), .div_clr(div_clr),
        .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_result(div_result), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        case (o)
            OP_MULT:  begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV:   return ref_div(a, b, 1'b1);
            OP_DIVU:  return ref_div(a, b, 1'b0);
            OP_MTHI:  return {a, model_lo};
            OP_MTLO:  return {model_hi, a};
            default:  return {model_hi, model_lo};
        endcase
    endfunction

    // Stand-in for the EXE-level divider: sample start, 33 busy cycles (1 for /0), wait for start low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_state <= 0; dv_cnt <= 0; div_busy <= 1'b0; div_result <= 64'd0;
        end else if (div_clr) begin
            dv_state <= 0; div_busy <= 1'b0;
        end else begin
            case (dv_state)
                0: if (div_start) begin
                    div_busy   <= 1'b1;
                    dv_cnt     <= (div_b == 32'd0) ? 0 : 32;
                    div_result <= ref_div(div_a, div_b, div_sign);
                    dv_state   <= 1;
                end
                1: if (dv_cnt == 0) begin
                    div_busy <= 1'b0;
                    dv_state <= 2;
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
                default: if (!div_start) dv_state <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of HI/LO against the architectural model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("hilo_vs_model", {hi, lo}, {model_hi, model_lo});
            check("div_clr_eq_flush", {63'd0, div_clr}, {63'd0, flush});
            if (!valid) check("no_stall_without_valid", {63'd0, stall}, 64'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one instruction (caller is at posedge+1), holds it until stall drops.
    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int hs_from);
        logic [63:0] m;
        int n;
        bit done;
        m = model_op(o, a, b);
        check({name, "_model"}, m, {exp_hi, exp_lo});
        valid = 1'b1; op = o; rs_val = a; rt_val = b;
        n = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                if (hs_from >= 0 && n >= hs_from)
                    check({name, "_handshake"}, {div_sign, div_a, div_b[31:1]},
                          {(o == OP_DIV), a, b[31:1]});
                n++;
            end
        end
        if (!done) check({name, "_timeout"}, 64'd1, 64'd0);
        check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        @(posedge clk);
        model_hi = m[63:32];
        model_lo = m[31:0];
        #1;
        valid = 1'b0; op = OP_NONE;
        check({name, "_result"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6; flush = 1'b0;
        #22;
        check("reset_outputs", {31'd0, stall, hi, lo}, 64'd0);
        check("reset_div", {div_start, div_sign, div_a, div_b[31:2]}, 64'd0);
        valid = 1'b0; op = OP_NONE;
        idle(1);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        issue("mthi", OP_MTHI, 32'h12345678, 32'd0, 0, 32'h12345678, 32'h00000000, -1);
        issue("mtlo", OP_MTLO, 32'h9ABCDEF0, 32'd0, 0, 32'h12345678, 32'h9ABCDEF0, -1);
        idle(1);
        issue("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, -1);
        idle(1);
        issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 32'hFFFFFFFE, -1);
        issue("mult_b2b", OP_MULT, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, -1);
        idle(1);
        issue("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
        idle(2);
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1);
        idle(1);
        issue("divu_by0", OP_DIVU, 32'd5, 32'd0, 3, 32'd0, 32'd0, 1);
        issue("div_after_rel", OP_DIV, 32'd20, 32'hFFFFFFFD, 36, 32'd2, 32'hFFFFFFFA, 2);
        idle(1);

        // Flush ten cycles into a divide.
        valid = 1'b1; op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd7;
        idle(10);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {63'd0, stall}, 64'd0);
        check("flush_clr", {63'd0, div_clr}, 64'd1);
        idle(1);
        flush = 1'b0; valid = 1'b0; op = OP_NONE;
        @(negedge clk);
        check("flush_release_start", {63'd0, div_start}, 64'd0);
        idle(1);
        issue("div_after_flush", OP_DIV, 32'hFFFFFF9C, 32'd7, 35, 32'hFFFFFFFE, 32'hFFFFFFF2, 1);
        idle(1);

        // Reset in the middle of a divide.
        valid = 1'b1; op = OP_DIV; rs_val = 32'd50; rt_val = 32'd5;
        idle(10);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {31'd0, stall, hi, lo}, 64'd0);
        check("midreset_div", {div_start, div_sign, div_a, div_b[31:2]}, 64'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        idle(1);
        valid = 1'b0; op = OP_NONE;
        rst_n = 1'b1;
        idle(1);
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 35, 32'd0, 32'd3, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
